// File: rtl/result_packer_if.sv
// result_packer_if
//   Bundles the request strobes from the system controller and the FIFO
//   write-port signals that surround result_packer.
//   master : controller/FIFO side (drives requests and FIFO_FULL, observes
//            the write port)
//   slave  : result_packer side
//   Signals:
//     ALU_OUT[15:0], OUT_VALID  ALU result and its one-cycle strobe
//     Rd_DATA[7:0],  Rd_Valid   register-file read data and its strobe
//     FIFO_FULL                 FIFO full flag (write domain)
//     WR_DATA[7:0],  WR_INC     byte and write strobe towards the FIFO
//     BUSY                      packer has work in flight
//     DROP_CNT[DROP_W-1:0]      saturating count of discarded requests
interface result_packer_if #(
  parameter int DROP_W = 8
);
  logic [15:0]       ALU_OUT;
  logic              OUT_VALID;
  logic [7:0]        Rd_DATA;
  logic              Rd_Valid;
  logic              FIFO_FULL;
  logic [7:0]        WR_DATA;
  logic              WR_INC;
  logic              BUSY;
  logic [DROP_W-1:0] DROP_CNT;

  modport master (
    output ALU_OUT, OUT_VALID, Rd_DATA, Rd_Valid, FIFO_FULL,
    input  WR_DATA, WR_INC, BUSY, DROP_CNT
  );

  modport slave (
    input  ALU_OUT, OUT_VALID, Rd_DATA, Rd_Valid, FIFO_FULL,
    output WR_DATA, WR_INC, BUSY, DROP_CNT
  );
endinterface

// File: rtl/result_packer.sv
// result_packer
//   Packs 16-bit ALU results and 8-bit register read data into a byte stream
//   for the async FIFO write port. One request is serialised from the active
//   slot while a second one can wait in the pending slot; anything beyond
//   that is discarded and counted.
//   Parameters:
//     LSB_FIRST  1: ALU_OUT[7:0] is sent first, 0: ALU_OUT[15:8] first
//     DROP_W     width of the saturating drop counter
//   Ports:
//     CLK  clock
//     RST  synchronous reset, active-high
//     bus  result_packer_if.slave (requests in, FIFO write port out)
module result_packer #(
  parameter bit LSB_FIRST = 1'b1,
  parameter int DROP_W    = 8
) (
  input  logic            CLK,
  input  logic            RST,
  result_packer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       act_data_reg, act_data_next;
  logic              act_alu_reg, act_alu_next;
  logic [15:0]       pend_data_reg, pend_data_next;
  logic              pend_alu_reg, pend_alu_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic              wr_inc;
  logic              last_byte;
  logic              done;
  logic              free_active;
  logic [7:0]        wr_data;
  logic [1:0]        drops;
  logic [DROP_W:0]   drop_sum;

  // Highest-priority new request (ALU beats REG); the second one, when both
  // strobes fire together, is always the REG request.
  logic              new_any;
  logic              new_two;
  logic              first_alu;
  logic [15:0]       first_data;
  logic [15:0]       second_data;

  assign new_any     = bus.OUT_VALID | bus.Rd_Valid;
  assign new_two     = bus.OUT_VALID & bus.Rd_Valid;
  assign first_alu   = bus.OUT_VALID;
  assign first_data  = bus.OUT_VALID ? bus.ALU_OUT : {8'h00, bus.Rd_DATA};
  assign second_data = {8'h00, bus.Rd_DATA};

  // Write strobe is combinational on FIFO_FULL so a byte goes out in the
  // same cycle the FIFO has room; it is forced low while reset is asserted.
  assign wr_inc    = (state_reg != IDLE) && !bus.FIFO_FULL && !RST;
  assign last_byte = (state_reg == SEND1) || ((state_reg == SEND0) && !act_alu_reg);
  assign done      = wr_inc && last_byte;
  // The active slot becomes free at this edge with nothing to promote.
  assign free_active = (state_reg == IDLE) || (done && !pend_valid_reg);

  always_comb begin
    wr_data = 8'h00;
    case (state_reg)
      SEND0: begin
        if (!act_alu_reg || LSB_FIRST)
          wr_data = act_data_reg[7:0];
        else
          wr_data = act_data_reg[15:8];
      end
      SEND1: begin
        if (LSB_FIRST)
          wr_data = act_data_reg[15:8];
        else
          wr_data = act_data_reg[7:0];
      end
      default: wr_data = 8'h00;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    act_data_next   = act_data_reg;
    act_alu_next    = act_alu_reg;
    pend_data_next  = pend_data_reg;
    pend_alu_next   = pend_alu_reg;
    pend_valid_next = pend_valid_reg;
    drops           = 2'd0;

    if (free_active) begin
      // Both slots are available: first request active, second pending.
      if (new_any) begin
        state_next    = SEND0;
        act_data_next = first_data;
        act_alu_next  = first_alu;
        if (new_two) begin
          pend_data_next  = second_data;
          pend_alu_next   = 1'b0;
          pend_valid_next = 1'b1;
        end
      end else begin
        state_next = IDLE;
      end
    end else if (done) begin
      // Promote pending without a bubble; pending can take one new request.
      state_next      = SEND0;
      act_data_next   = pend_data_reg;
      act_alu_next    = pend_alu_reg;
      pend_valid_next = 1'b0;
      if (new_any) begin
        pend_data_next  = first_data;
        pend_alu_next   = first_alu;
        pend_valid_next = 1'b1;
      end
      if (new_two)
        drops = 2'd1;
    end else begin
      if (wr_inc && (state_reg == SEND0))
        state_next = SEND1;
      if (!pend_valid_reg) begin
        if (new_any) begin
          pend_data_next  = first_data;
          pend_alu_next   = first_alu;
          pend_valid_next = 1'b1;
        end
        if (new_two)
          drops = 2'd1;
      end else begin
        drops = {1'b0, bus.OUT_VALID} + {1'b0, bus.Rd_Valid};
      end
    end

    // One extra bit of headroom detects wrap; clamp to all-ones.
    drop_sum = {1'b0, drop_cnt_reg} + {{(DROP_W-1){1'b0}}, drops};
    if (drop_sum[DROP_W])
      drop_cnt_next = {DROP_W{1'b1}};
    else
      drop_cnt_next = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      act_data_reg   <= 16'h0000;
      act_alu_reg    <= 1'b0;
      pend_data_reg  <= 16'h0000;
      pend_alu_reg   <= 1'b0;
      pend_valid_reg <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      act_data_reg   <= act_data_next;
      act_alu_reg    <= act_alu_next;
      pend_data_reg  <= pend_data_next;
      pend_alu_reg   <= pend_alu_next;
      pend_valid_reg <= pend_valid_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  assign bus.WR_DATA  = wr_data;
  assign bus.WR_INC   = wr_inc;
  assign bus.BUSY     = (state_reg != IDLE) || pend_valid_reg;
  assign bus.DROP_CNT = drop_cnt_reg;

endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer
//   Drives two packers (LSB_FIRST=1 and LSB_FIRST=0) with identical directed
//   stimulus. A request-queue model (at most two outstanding requests,
//   one byte leaves per non-full cycle) predicts every output on every cycle;
//   literal byte-stream and counter expectations pin each scenario.
module tb_result_packer;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  result_packer_if #(.DROP_W(8)) ifa ();
  result_packer_if #(.DROP_W(8)) ifb ();

  result_packer #(.LSB_FIRST(1'b1), .DROP_W(8)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (ifa.slave)
  );

  result_packer #(.LSB_FIRST(1'b0), .DROP_W(8)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (ifb.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  // ---------------- model: queue of outstanding requests ----------------
  typedef struct packed {
    logic        alu;
    logic [15:0] data;
    logic [1:0]  sent;
  } req_t;

  req_t mq[$];
  int   mdrop = 0;

  task automatic add_req(input logic alu, input logic [15:0] data);
    req_t r;
    r.alu  = alu;
    r.data = data;
    r.sent = 2'd0;
    if (mq.size() < 2)
      mq.push_back(r);
    else if (mdrop < 255)
      mdrop++;
  endtask

  function automatic logic [7:0] exp_byte(input bit lsb);
    req_t h;
    if (mq.size() == 0) return 8'h00;
    h = mq[0];
    if (!h.alu) return h.data[7:0];
    if ((h.sent == 2'd0) == lsb) return h.data[7:0];
    return h.data[15:8];
  endfunction

  always @(posedge CLK) begin : model
    req_t h;
    if (RST) begin
      mq.delete();
      mdrop = 0;
    end else begin
      if (mq.size() != 0 && !ifa.FIFO_FULL) begin
        h = mq[0];
        h.sent = h.sent + 2'd1;
        if (h.sent == (h.alu ? 2'd2 : 2'd1))
          void'(mq.pop_front());
        else
          mq[0] = h;
      end
      if (ifa.OUT_VALID) add_req(1'b1, ifa.ALU_OUT);
      if (ifa.Rd_Valid)  add_req(1'b0, {8'h00, ifa.Rd_DATA});
    end
  end

  // ---------------- per-cycle compare + push logs ----------------
  logic        chk_en = 1'b0;
  logic [31:0] la_pk = 0, lb_pk = 0;
  int          la_n = 0, lb_n = 0;

  always begin : compare
    logic busy_e, inc_e;
    @(negedge CLK);
    #1;
    if (chk_en) begin
      busy_e = (mq.size() != 0);
      inc_e  = busy_e && !ifa.FIFO_FULL && !RST;
      check("cyc_wr_inc_a",  ifa.WR_INC,   inc_e);
      check("cyc_wr_inc_b",  ifb.WR_INC,   inc_e);
      check("cyc_wr_data_a", ifa.WR_DATA,  exp_byte(1'b1));
      check("cyc_wr_data_b", ifb.WR_DATA,  exp_byte(1'b0));
      check("cyc_busy_a",    ifa.BUSY,     busy_e);
      check("cyc_busy_b",    ifb.BUSY,     busy_e);
      check("cyc_drop_a",    ifa.DROP_CNT, mdrop[7:0]);
      check("cyc_drop_b",    ifb.DROP_CNT, mdrop[7:0]);
      if (ifa.WR_INC) begin la_pk = {la_pk[23:0], ifa.WR_DATA}; la_n++; end
      if (ifb.WR_INC) begin lb_pk = {lb_pk[23:0], ifb.WR_DATA}; lb_n++; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit av, input logic [15:0] a, input bit rv,
                       input logic [7:0] d, input bit full);
    ifa.OUT_VALID = av; ifa.ALU_OUT = a; ifa.Rd_Valid = rv; ifa.Rd_DATA = d; ifa.FIFO_FULL = full;
    ifb.OUT_VALID = av; ifb.ALU_OUT = a; ifb.Rd_Valid = rv; ifb.Rd_DATA = d; ifb.FIFO_FULL = full;
  endtask

  task automatic step(input bit av, input logic [15:0] a, input bit rv,
                      input logic [7:0] d, input bit full, input bit rst);
    drive(av, a, rv, d, full);
    RST = rst;
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input bit full);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 8'h0, full, 1'b0);
  endtask

  task automatic clear_log();
    la_pk = 0; lb_pk = 0; la_n = 0; lb_n = 0;
  endtask

  task automatic check_logs(input string name, input int na, input logic [31:0] pa,
                            input int nb, input logic [31:0] pb);
    check({name, "_a"}, {la_n[31:0], la_pk}, {na[31:0], pa});
    check({name, "_b"}, {lb_n[31:0], lb_pk}, {nb[31:0], pb});
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;

    // Reset state
    check("rst_wr_inc", ifa.WR_INC, 1'b0);
    check("rst_busy",   ifa.BUSY, 1'b0);
    check("rst_wr_data", ifa.WR_DATA, 8'h00);
    check("rst_drop",   ifa.DROP_CNT, 8'h00);

    // Single REG
    clear_log();
    step(1'b0, 16'h0, 1'b1, 8'h5A, 1'b0, 1'b0);
    idle(3, 1'b0);
    check_logs("single_reg", 1, 32'h5A, 1, 32'h5A);
    check("single_reg_busy", ifa.BUSY, 1'b0);

    // Single ALU, both byte orders
    clear_log();
    step(1'b1, 16'hBEEF, 1'b0, 8'h0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check_logs("single_alu", 2, 32'hEFBE, 2, 32'hBEEF);

    // Back-pressure between the two ALU bytes
    clear_log();
    step(1'b1, 16'h1234, 1'b0, 8'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("bp_first_push", la_n, 1);
    idle(5, 1'b1);
    check("bp_held", la_n, 1);
    idle(3, 1'b0);
    check_logs("backpressure", 2, 32'h3412, 2, 32'h1234);

    // Simultaneous ALU + REG
    clear_log();
    step(1'b1, 16'hA0B1, 1'b1, 8'hC2, 1'b0, 1'b0);
    idle(4, 1'b0);
    check_logs("simultaneous", 3, 32'hB1A0C2, 3, 32'hA0B1C2);
    check("simultaneous_drop", ifa.DROP_CNT, 8'd0);

    // Overflow: third request while both slots are full
    clear_log();
    step(1'b1, 16'h1357, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 8'h22, 1'b1, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 8'h00, 1'b1, 1'b0);
    check("overflow_drop", ifa.DROP_CNT, 8'd1);
    idle(5, 1'b0);
    check_logs("overflow", 3, 32'h571322, 3, 32'h135722);

    // Saturation: two drops per edge, 150 edges
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b1);
    clear_log();
    step(1'b1, 16'hAAAA, 1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 16'hAAAA, 1'b1, 8'h55, 1'b1, 1'b0);
    check("double_drop", ifa.DROP_CNT, 8'd2);
    for (int i = 0; i < 149; i++) step(1'b1, 16'hAAAA, 1'b1, 8'h55, 1'b1, 1'b0);
    check("sat_drop_a", ifa.DROP_CNT, 8'hFF);
    check("sat_drop_b", ifb.DROP_CNT, 8'hFF);
    idle(4, 1'b0);
    check_logs("sat_drain", 3, 32'hAAAA55, 3, 32'hAAAA55);

    // Reset mid-operation with pending occupied
    step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b1);
    clear_log();
    step(1'b1, 16'hABCD, 1'b1, 8'h77, 1'b0, 1'b0);
    idle(1, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    RST = 1'b1;
    #1;
    check("rst_mid_wr_inc", ifa.WR_INC, 1'b0);
    @(negedge CLK);
    idle(4, 1'b0);
    check_logs("rst_mid", 1, 32'hCD, 1, 32'hAB);
    check("rst_mid_busy", ifa.BUSY, 1'b0);
    check("rst_mid_data", ifa.WR_DATA, 8'h00);
    check("rst_mid_drop", ifa.DROP_CNT, 8'h00);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
